mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences the single unified memory port between instruction fetch (IF) and the MEM stage of the pipelined ARM core. Accepts one request at a time, holds the request fields stable on the memory side until the memory acknowledges, and returns read data. Generates the stall signals the hazard logic uses to freeze IF and the MEM pipeline register while an access is outstanding. Data accesses have fixed priority over fetches.

## Interface
- `TIMEOUT_CYCLES`, 16: cycles `ramReq` may stay high without `ramReady` before the access is aborted (only with `MEM_PORT_TIMEOUT_EN`); legal range 2..255.
- `clk` in 1: clock, all state updates on rising edge.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `ifReq` in 1: fetch read request; held high with `ifAddr` stable until `ifValid`.
- `ifAddr` in 32: fetch address.
- `memReq` in 1: MEM-stage request (`MemtoRegM | MemWriteM`); held with fields stable until `memValid`.
- `memWrite` in 1: 1 = write, 0 = read.
- `memAddr` in 32: data address (`ALUResultM`).
- `memWData` in 32: write data (`WriteDataM`).
- `memByteEn` in 4: byte enables (`byteEnableM`).
- `ramReady` in 1: memory acknowledge for the current `ramReq`.
- `ramRData` in 32: memory read data, valid when `ramReady`.
- `ramReq`, `ramWe` out 1: memory request / write strobe.
- `ramAddr`, `ramWData` out 32; `ramByteEn` out 4: registered request fields.
- `ifRData` out 32; `ifValid` out 1: fetch data and 1-cycle completion pulse.
- `memRData` out 32; `memValid` out 1: load data and 1-cycle completion pulse.
- `StallF`, `StallM` out 1: combinational, `ifReq & ~ifValid` and `memReq & ~memValid`.
- `timeoutErr` out 1: sticky abort flag.

## Operation
- States: IDLE, DATA, FETCH, RESP.
- IDLE: if `memReq` -> capture `memAddr/memWData/memByteEn/memWrite`, go DATA; else if `ifReq` -> capture `ifAddr`, `ramWe`=0, `ramByteEn`=4'hF, go FETCH; else stay.
- DATA/FETCH: `ramReq`=1, fields constant. On `ramReady`=1: go RESP, register owner. For DATA read: `memRData`<=`ramRData`; for FETCH: `ifRData`<=`ramRData`; for DATA write: `memRData` unchanged.
- RESP: owner's valid pulses 1 for exactly this cycle; `ramReq`=0; no grant evaluated (requester still holds its request this cycle); next IDLE.
- Simultaneous `memReq` and `ifReq` in IDLE: data wins; fetch waits, `StallF` stays high.
- Requests dropped by a requester mid-access are ignored; the access completes and the pulse is still emitted.
- `ifRData`/`memRData` hold last value between accesses.

## Timing
- Reset: state IDLE; `ramReq`, `ramWe`, `ifValid`, `memValid`, `timeoutErr` = 0; `ramAddr`, `ramWData`, `ifRData`, `memRData` = 0; `ramByteEn` = 0.
- Reset mid-access: access abandoned; `ramReq` low on cycle after reset edge; no valid pulse.
- Request seen in IDLE at cycle 0 -> `ramReq` high cycles 1..k where `ramReady` sampled high at cycle k (k>=1) -> valid at k+1 -> IDLE at k+2 -> next `ramReq` at k+3.
- Zero-wait memory (`ramReady` high at cycle 1): 3-cycle round trip, 4 cycles between back-to-back grants.
- `ramReady` while `ramReq`=0 is ignored.

## Configuration
- `MEM_PORT_TIMEOUT_EN` defined: 8-bit counter clears on each grant, increments each DATA/FETCH cycle with `ramReady`=0; when it reaches `TIMEOUT_CYCLES`, go RESP, owner's read data = 32'hDEADBEEF (writes: data unchanged), `timeoutErr` set and held until `reset`.
- Undefined: no counter; access waits indefinitely; `timeoutErr` tied 0.

## Test plan
- Fetch only, `ifAddr`=0x100, `ramReady` at cycle 1 with 0xE3A00001 -> `ramReq` cycle 1 only, `ifValid` cycle 2, `ifRData`=0xE3A00001, `StallF` 1 in cycles 0-1, 0 at cycle 2.
- `memReq` write 0x200, data 0x12345678, `memByteEn`=4'b0011, ready after 3 waits -> `ramWe`=1, `ramByteEn`=0011 cycles 1-4, `memValid` cycle 5, `memRData` unchanged.
- `memReq` and `ifReq` raised same cycle, zero-wait -> data `ramReq` cycle 1, `memValid` cycle 2, fetch `ramReq` cycle 4, `ifValid` cycle 5.
- `reset` asserted at cycle 2 of a 5-wait load -> `ramReq`=0 cycle 3, no `memValid`, all outputs zero, new request granted normally after.
- With `MEM_PORT_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `ramReady` never -> `memValid` pulse, `memRData`=0xDEADBEEF, `timeoutErr`=1 persisting until `reset`.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, memory and response signals of the unified memory port.
interface mem_port_if;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic        memReq;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [3:0]  memByteEn;
  logic        ramReady;
  logic [31:0] ramRData;
  logic        ramReq;
  logic        ramWe;
  logic [31:0] ramAddr;
  logic [31:0] ramWData;
  logic [3:0]  ramByteEn;
  logic [31:0] ifRData;
  logic        ifValid;
  logic [31:0] memRData;
  logic        memValid;
  logic        StallF;
  logic        StallM;
  logic        timeoutErr;
  modport slave (
    input  ifReq, ifAddr, memReq, memWrite, memAddr, memWData, memByteEn, ramReady, ramRData,
    output ramReq, ramWe, ramAddr, ramWData, ramByteEn, ifRData, ifValid, memRData, memValid,
           StallF, StallM, timeoutErr
  );
  modport master (
    output ifReq, ifAddr, memReq, memWrite, memAddr, memWData, memByteEn, ramReady, ramRData,
    input  ramReq, ramWe, ramAddr, ramWData, ramByteEn, ifRData, ifValid, memRData, memValid,
           StallF, StallM, timeoutErr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and MEM stage, data first.
// Define MEM_PORT_TIMEOUT_EN to abort accesses left unacknowledged for TIMEOUT_CYCLES.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic       clk,
  input logic       reset,
  mem_port_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DATA, FETCH, RESP} state_t;
  state_t      state_q;
  logic        ram_req_q, ram_we_q, if_valid_q, mem_valid_q;
  logic [31:0] ram_addr_q, ram_wdata_q, if_rdata_q, mem_rdata_q;
  logic [3:0]  ram_be_q;
  logic        busy, tmo, done;
  logic [31:0] rdata;
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be 2..255");
  end
  assign busy  = (state_q == DATA) || (state_q == FETCH);
  assign done  = busy & (bus.ramReady | tmo);
  assign rdata = tmo ? 32'hDEADBEEF : bus.ramRData;
`ifdef MEM_PORT_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;
  assign tmo = busy & ~bus.ramReady & (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= busy ? cnt_q + 8'd1 : 8'd0;
      if (tmo) err_q <= 1'b1;
    end
  end
  assign bus.timeoutErr = err_q;
`else
  assign tmo            = 1'b0;
  assign bus.timeoutErr = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_be_q    <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
    end else begin
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.memReq) begin
            state_q     <= DATA;
            ram_req_q   <= 1'b1;
            ram_we_q    <= bus.memWrite;
            ram_addr_q  <= bus.memAddr;
            ram_wdata_q <= bus.memWData;
            ram_be_q    <= bus.memByteEn;
          end else if (bus.ifReq) begin
            state_q    <= FETCH;
            ram_req_q  <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_addr_q <= bus.ifAddr;
            ram_be_q   <= 4'hF;
          end
        end
        DATA: begin
          if (done) begin
            state_q     <= RESP;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            mem_valid_q <= 1'b1;
            if (!ram_we_q) mem_rdata_q <= rdata;
          end
        end
        FETCH: begin
          if (done) begin
            state_q    <= RESP;
            ram_req_q  <= 1'b0;
            if_valid_q <= 1'b1;
            if_rdata_q <= rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.ramReq    = ram_req_q;
  assign bus.ramWe     = ram_we_q;
  assign bus.ramAddr   = ram_addr_q;
  assign bus.ramWData  = ram_wdata_q;
  assign bus.ramByteEn = ram_be_q;
  assign bus.ifRData   = if_rdata_q;
  assign bus.ifValid   = if_valid_q;
  assign bus.memRData  = mem_rdata_q;
  assign bus.memValid  = mem_valid_q;
  assign bus.StallF    = bus.ifReq & ~if_valid_q;
  assign bus.StallM    = bus.memReq & ~mem_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: transaction-level reference checks of the memory port arbiter.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_if, exp_mem;
  logic        exp_err;
  mem_port_if bus ();
  mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input bit is_mem, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be_in, input logic [31:0] rd, input int waits);
    logic [3:0] be;
    be = is_mem ? be_in : 4'hF;
    next_cycle();
    bus.ifReq = !is_mem; bus.ifAddr = a;
    bus.memReq = is_mem; bus.memWrite = wr; bus.memAddr = a; bus.memWData = d; bus.memByteEn = be_in;
    bus.ramReady = 1'($urandom); bus.ramRData = $urandom;
    @(negedge clk);
    chk("req_c0", bus.ramReq, 0);
    chk("stall_c0", is_mem ? bus.StallM : bus.StallF, 1);
    for (int c = 1; c <= waits + 1; c++) begin
      next_cycle();
      bus.ramReady = (c == waits + 1);
      bus.ramRData = (c == waits + 1) ? rd : $urandom;
      @(negedge clk);
      chk("ramReq", bus.ramReq, 1);
      chk("ramAddr", bus.ramAddr, a);
      chk("ramWe", bus.ramWe, is_mem & wr);
      chk("ramByteEn", bus.ramByteEn, be);
      if (is_mem) chk("ramWData", bus.ramWData, d);
      chk("stall_busy", is_mem ? bus.StallM : bus.StallF, 1);
      chk("valid_early", bus.ifValid | bus.memValid, 0);
    end
    next_cycle();
    bus.ramReady = 1'($urandom); bus.ramRData = $urandom;
    if (is_mem && !wr) exp_mem = rd;
    if (!is_mem) exp_if = rd;
    @(negedge clk);
    chk("ifValid", bus.ifValid, !is_mem);
    chk("memValid", bus.memValid, is_mem);
    chk("ramReq_resp", bus.ramReq, 0);
    chk("ifRData", bus.ifRData, exp_if);
    chk("memRData", bus.memRData, exp_mem);
    chk("stall_resp", bus.StallF | bus.StallM, 0);
    chk("timeoutErr", bus.timeoutErr, exp_err);
    next_cycle();
    bus.ifReq = 0; bus.memReq = 0;
    @(negedge clk);
    chk("ramReq_idle", bus.ramReq, 0);
    chk("valid_idle", bus.ifValid | bus.memValid, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ramReq"}, bus.ramReq, 0);
    chk({tag, "_ramWe"}, bus.ramWe, 0);
    chk({tag, "_ramAddr"}, bus.ramAddr, 0);
    chk({tag, "_ramWData"}, bus.ramWData, 0);
    chk({tag, "_ramByteEn"}, bus.ramByteEn, 0);
    chk({tag, "_ifRData"}, bus.ifRData, 0);
    chk({tag, "_memRData"}, bus.memRData, 0);
    chk({tag, "_valid"}, bus.ifValid | bus.memValid, 0);
    chk({tag, "_timeoutErr"}, bus.timeoutErr, 0);
  endtask

  initial begin
    logic [31:0] rd1, rd2, ma, fa;
    reset = 1'b1;
    bus.ifReq = 0; bus.ifAddr = 0; bus.memReq = 0; bus.memWrite = 0; bus.memAddr = 0;
    bus.memWData = 0; bus.memByteEn = 0; bus.ramReady = 0; bus.ramRData = 0;
    exp_if = 0; exp_mem = 0; exp_err = 0;
    next_cycle();
    @(negedge clk);
    check_zero("reset");
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      bus.ramReady = 1'b1; bus.ramRData = $urandom;
      @(negedge clk);
      chk("idle_ready_ignored", bus.ramReq | bus.ifValid | bus.memValid, 0);
    end
    bus.ramReady = 1'b0;
    access(0, 0, 32'h100, 32'h0, 4'hF, 32'hE3A00001, 0);
    access(1, 1, 32'h200, 32'h12345678, 4'b0011, 32'hCAFEF00D, 3);
    for (int i = 0; i < 24; i++)
      access(1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom), $urandom,
             int'($urandom_range(0, 3)));
    // both requesters at once: data granted first, fetch after the data response
    ma = $urandom; fa = $urandom; rd1 = $urandom; rd2 = $urandom;
    next_cycle();
    bus.memReq = 1; bus.memWrite = 0; bus.memAddr = ma; bus.memByteEn = 4'b0101;
    bus.ifReq = 1; bus.ifAddr = fa; bus.ramReady = 1; bus.ramRData = rd1;
    @(negedge clk);
    chk("arb_c0_stalls", {30'd0, bus.StallF, bus.StallM}, 3);
    next_cycle();
    @(negedge clk);
    chk("arb_c1_ramReq", bus.ramReq, 1);
    chk("arb_c1_ramAddr", bus.ramAddr, ma);
    next_cycle();
    bus.ramRData = rd2;
    exp_mem = rd1;
    @(negedge clk);
    chk("arb_c2_memValid", bus.memValid, 1);
    chk("arb_c2_memRData", bus.memRData, exp_mem);
    chk("arb_c2_StallF", bus.StallF, 1);
    chk("arb_c2_ramReq", bus.ramReq, 0);
    next_cycle();
    bus.memReq = 0;
    @(negedge clk);
    chk("arb_c3_ramReq", bus.ramReq, 0);
    chk("arb_c3_StallF", bus.StallF, 1);
    next_cycle();
    @(negedge clk);
    chk("arb_c4_ramReq", bus.ramReq, 1);
    chk("arb_c4_ramAddr", bus.ramAddr, fa);
    chk("arb_c4_ramByteEn", bus.ramByteEn, 4'hF);
    chk("arb_c4_ramWe", bus.ramWe, 0);
    next_cycle();
    exp_if = rd2;
    @(negedge clk);
    chk("arb_c5_ifValid", bus.ifValid, 1);
    chk("arb_c5_ifRData", bus.ifRData, exp_if);
    chk("arb_c5_memRData", bus.memRData, exp_mem);
    next_cycle();
    bus.ifReq = 0; bus.ramReady = 0;
    // reset in the middle of a long load abandons it without a response
    next_cycle();
    bus.memReq = 1; bus.memWrite = 0; bus.memAddr = $urandom; bus.memByteEn = 4'hF;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_c2_ramReq", bus.ramReq, 1);
    next_cycle();
    reset = 1'b0; bus.memReq = 0;
    exp_if = 0; exp_mem = 0;
    @(negedge clk);
    check_zero("rst_mid");
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      chk("rst_no_valid", bus.memValid | bus.ramReq, 0);
    end
    access(1, 0, $urandom, $urandom, 4'hF, $urandom, 1);
    access(0, 0, $urandom, $urandom, 4'hF, $urandom, 2);
`ifdef MEM_PORT_TIMEOUT_EN
    next_cycle();
    bus.memReq = 1; bus.memWrite = 0; bus.memAddr = 32'h300; bus.memByteEn = 4'hF; bus.ramReady = 0;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      @(negedge clk);
      chk("tmo_ramReq", bus.ramReq, 1);
      chk("tmo_memValid_early", bus.memValid, 0);
    end
    next_cycle();
    exp_mem = 32'hDEADBEEF; exp_err = 1;
    @(negedge clk);
    chk("tmo_memValid", bus.memValid, 1);
    chk("tmo_memRData", bus.memRData, exp_mem);
    chk("tmo_err", bus.timeoutErr, exp_err);
    next_cycle();
    bus.memReq = 0;
    access(0, 0, $urandom, $urandom, 4'hF, $urandom, 1);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    exp_err = 0; exp_if = 0; exp_mem = 0;
    @(negedge clk);
    chk("tmo_err_cleared", bus.timeoutErr, exp_err);
`else
    access(1, 0, $urandom, $urandom, 4'hF, $urandom, 20);
    chk("no_timeout_err", bus.timeoutErr, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
